// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants: block layout, padding marker,
// padder state encoding and the initial hash values.
package sha256_pkg;

  // Word i of a block sits at [32i+31:32i]; W0 is the least significant word.
  typedef logic [15:0][31:0] block_t;

  localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    EMIT = 2'd2
  } pad_state_e;

  localparam logic [31:0] SHA256_H0 = 32'h6a09_e667;
  localparam logic [31:0] SHA256_H1 = 32'hbb67_ae85;
  localparam logic [31:0] SHA256_H2 = 32'h3c6e_f372;
  localparam logic [31:0] SHA256_H3 = 32'ha54f_f53a;
  localparam logic [31:0] SHA256_H4 = 32'h510e_527f;
  localparam logic [31:0] SHA256_H5 = 32'h9b05_688c;
  localparam logic [31:0] SHA256_H6 = 32'h1f83_d9ab;
  localparam logic [31:0] SHA256_H7 = 32'h5be0_cd19;

endpackage

// File: rtl/sha256_last_word_pad.sv
// Formats the final message word: keeps the left-aligned valid bytes,
// places the 0x80 marker right after them and clears the rest. A full
// word leaves no room, so the marker moves to the following slot.
module sha256_last_word_pad (
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o,
  output logic        marker_in_next_o
);

  logic [2:0] n_clamped;

  // Byte-wise mask and marker insertion; counts above 4 behave as 4.
  always_comb begin
    n_clamped        = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
    marker_in_next_o = (n_clamped == 3'd4);
    word_o           = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n_clamped) begin
        word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
      end else if (3'(b) == n_clamped) begin
        word_o[31-8*b -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects a big-endian 32-bit word stream into
// 512-bit blocks, appends the 0x80 marker, zero fill and the 64-bit bit
// length, and hands complete blocks downstream with first/last flags.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy
);

  pad_state_e       state_q;
  logic [3:0]       wcnt_q;
  logic [LEN_W-1:0] len_q;
  logic             first_q;
  logic             pend_q;
  logic             mnext_q;
  logic             bfirst_q;
  logic             blast_q;
  logic             busy_q;
  block_t           blk_q;

  logic [31:0]      last_word;
  logic             marker_next;
  logic             accept;
  logic [LEN_W-1:0] len_add;
  logic [LEN_W-1:0] len_d;
  logic [63:0]      len64_d;
  logic [63:0]      len64_q;
  logic [4:0]       mark_slot;
  logic             fits;
  block_t           fill_blk;
  block_t           pad_blk;

  sha256_last_word_pad u_last_word_pad (
    .data_i           (in_data),
    .nbytes_i         (in_nbytes),
    .word_o           (last_word),
    .marker_in_next_o (marker_next)
  );

  assign accept  = in_valid && (state_q == FILL);
  assign len64_d = 64'(len_d);
  assign len64_q = 64'(len_q);

  // Length bookkeeping: a full word adds 32 bits, a short final word 8 per byte.
  always_comb begin
    if (!in_last || marker_next) begin
      len_add = LEN_W'(32);
    end else begin
      len_add = LEN_W'({in_nbytes[1:0], 3'b000});
    end
    len_d     = len_q + len_add;
    mark_slot = {1'b0, wcnt_q} + {4'b0000, marker_next};
    fits      = (mark_slot <= 5'd13);
  end

  // Block image after the accepted word, including all padding for a final word.
  always_comb begin
    fill_blk = blk_q;
    if (in_last) begin
      fill_blk[wcnt_q] = marker_next ? in_data : last_word;
      for (int i = 0; i < 16; i++) begin
        if (marker_next && (5'(i) == mark_slot)) begin
          fill_blk[i] = PAD_MARKER;
        end else if (5'(i) > mark_slot) begin
          fill_blk[i] = '0;
        end
      end
      if (fits) begin
        fill_blk[14] = len64_d[63:32];
        fill_blk[15] = len64_d[31:0];
      end
    end else begin
      fill_blk[wcnt_q] = in_data;
    end
  end

  // Extra length-only block, carrying the marker if it did not fit before.
  always_comb begin
    pad_blk     = '0;
    pad_blk[0]  = mnext_q ? PAD_MARKER : 32'h0;
    pad_blk[14] = len64_q[63:32];
    pad_blk[15] = len64_q[31:0];
  end

  // Control FSM with the block register, length counter and output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      mnext_q  <= 1'b0;
      bfirst_q <= 1'b0;
      blast_q  <= 1'b0;
      busy_q   <= 1'b0;
      blk_q    <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            blk_q  <= fill_blk;
            len_q  <= len_d;
            busy_q <= 1'b1;
            if (in_last) begin
              wcnt_q   <= '0;
              state_q  <= EMIT;
              bfirst_q <= first_q;
              blast_q  <= fits;
              pend_q   <= !fits;
              mnext_q  <= (mark_slot == 5'd16);
            end else if (wcnt_q == 4'd15) begin
              wcnt_q   <= '0;
              state_q  <= EMIT;
              bfirst_q <= first_q;
              blast_q  <= 1'b0;
              pend_q   <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        PAD: begin
          blk_q    <= pad_blk;
          state_q  <= EMIT;
          bfirst_q <= first_q;
          blast_q  <= 1'b1;
          pend_q   <= 1'b0;
        end
        EMIT: begin
          if (blk_ready) begin
            first_q  <= 1'b0;
            bfirst_q <= 1'b0;
            blast_q  <= 1'b0;
            if (blast_q) begin
              len_q   <= '0;
              first_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FILL;
            end else if (pend_q) begin
              state_q <= PAD;
            end else begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = blk_q;
  assign blk_first = bfirst_q;
  assign blk_last  = blast_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of message lengths checked
// against a byte-level padding model, plus hand-written abc, empty,
// backpressure and mid-message reset sequences.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    block_t d;
    logic   f;
    logic   l;
  } rec_t;

  typedef struct {
    int          nb;
    bit          extra;
    bit          big;
    int          exp_blocks;
    logic [31:0] exp_len;
  } vec_t;

  rec_t   got_q[$];
  block_t exp_q[$];
  vec_t   vecs[16];

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Record every handshake: bench only changes blk_ready just after posedge.
  always @(negedge clk) begin
    if (reset_n && blk_valid && blk_ready) begin
      got_q.push_back('{d: blk_data, f: blk_first, l: blk_last});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int j);
    return 8'((j * 37 + 11) & 255);
  endfunction

  // Word k of an nb-byte message; bytes past the end carry junk.
  function automatic logic [31:0] mk_word(input int nb, input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      w = {w[23:0], ((4 * k + b) < nb) ? msg_byte(4 * k + b) : 8'hA5};
    end
    return w;
  endfunction

  // Reference padding built on a byte list, split into blocks afterwards.
  function automatic void build_exp(input int nb);
    logic [7:0]  q[$];
    logic [63:0] bits;
    block_t      blk;
    int          base;
    bits = 64'(nb) * 64'd8;
    for (int j = 0; j < nb; j++) q.push_back(msg_byte(j));
    q.push_back(8'h80);
    while ((q.size() % 64) != 56) q.push_back(8'h00);
    for (int s = 7; s >= 0; s--) q.push_back(8'(bits >> (8 * s)));
    exp_q.delete();
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int w = 0; w < 16; w++) begin
        base   = 64 * b + 4 * w;
        blk[w] = {q[base], q[base+1], q[base+2], q[base+3]};
      end
      exp_q.push_back(blk);
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input logic lst, input logic [2:0] nb);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = lst;
    in_nbytes = nb;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (done) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic send_msg(input int nb, input bit extra, input bit big);
    int         nw;
    int         rem;
    bit         lst;
    logic [2:0] code;
    nw = (nb + 3) / 4;
    if (nb == 0) begin
      send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    end else begin
      for (int k = 0; k < nw; k++) begin
        lst  = (k == nw - 1) && !extra;
        rem  = nb - 4 * k;
        code = !lst ? 3'd0 : ((rem >= 4) ? (big ? 3'd6 : 3'd4) : 3'(rem));
        send_word(mk_word(nb, k), lst, code);
      end
      if (extra) send_word(32'h1234_5678, 1'b1, 3'd0);
    end
  endtask

  task automatic wait_blocks(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  block_t abc_blk;
  block_t empty_blk;
  block_t snap;
  int     nchk;

  initial begin
    vecs[0]  = '{nb: 0,   extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h0};
    vecs[1]  = '{nb: 3,   extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h18};
    vecs[2]  = '{nb: 4,   extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h20};
    vecs[3]  = '{nb: 5,   extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h28};
    vecs[4]  = '{nb: 8,   extra: 1, big: 0, exp_blocks: 1, exp_len: 32'h40};
    vecs[5]  = '{nb: 52,  extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h1A0};
    vecs[6]  = '{nb: 55,  extra: 0, big: 0, exp_blocks: 1, exp_len: 32'h1B8};
    vecs[7]  = '{nb: 56,  extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h1C0};
    vecs[8]  = '{nb: 57,  extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h1C8};
    vecs[9]  = '{nb: 60,  extra: 0, big: 1, exp_blocks: 2, exp_len: 32'h1E0};
    vecs[10] = '{nb: 63,  extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h1F8};
    vecs[11] = '{nb: 64,  extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h200};
    vecs[12] = '{nb: 64,  extra: 1, big: 0, exp_blocks: 2, exp_len: 32'h200};
    vecs[13] = '{nb: 65,  extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h208};
    vecs[14] = '{nb: 119, extra: 0, big: 0, exp_blocks: 2, exp_len: 32'h3B8};
    vecs[15] = '{nb: 120, extra: 0, big: 0, exp_blocks: 3, exp_len: 32'h3C0};

    abc_blk       = '0;
    abc_blk[0]    = 32'h6162_6380;
    abc_blk[15]   = 32'h0000_0018;
    empty_blk     = '0;
    empty_blk[0]  = 32'h8000_0000;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    blk_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_first", 64'(blk_first), 64'd0);
    chk("rst_blk_last",  64'(blk_last),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk_blk("rst_blk_data", blk_data, '0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // "abc"
    got_q.delete();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_blocks(1);
    chk("abc_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      chk_blk("abc_data", got_q[0].d, abc_blk);
      chk("abc_first", 64'(got_q[0].f), 64'd1);
      chk("abc_last",  64'(got_q[0].l), 64'd1);
    end
    chk("abc_busy_done", 64'(busy), 64'd0);

    // Empty message
    got_q.delete();
    send_word(32'h0, 1'b1, 3'd0);
    wait_blocks(1);
    chk("empty_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      chk_blk("empty_data", got_q[0].d, empty_blk);
      chk("empty_first", 64'(got_q[0].f), 64'd1);
      chk("empty_last",  64'(got_q[0].l), 64'd1);
    end

    // Table of message lengths, sent back to back
    for (int v = 0; v < 16; v++) begin
      got_q.delete();
      build_exp(vecs[v].nb);
      send_msg(vecs[v].nb, vecs[v].extra, vecs[v].big);
      wait_blocks(vecs[v].exp_blocks);
      chk($sformatf("v%0d_count", v), 64'(got_q.size()), 64'(vecs[v].exp_blocks));
      nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++) begin
        chk_blk($sformatf("v%0d_blk%0d", v, i), got_q[i].d, exp_q[i]);
        chk($sformatf("v%0d_first%0d", v, i), 64'(got_q[i].f), 64'(i == 0));
        chk($sformatf("v%0d_last%0d", v, i), 64'(got_q[i].l), 64'(i == nchk - 1));
      end
      if (got_q.size() > 0) begin
        chk($sformatf("v%0d_lenword", v), 64'(got_q[got_q.size()-1].d[15]), 64'(vecs[v].exp_len));
      end
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
    end

    // Backpressure on the first block of a 56-byte message
    got_q.delete();
    build_exp(56);
    blk_ready = 1'b0;
    send_msg(56, 1'b0, 1'b0);
    @(negedge clk);
    snap = blk_data;
    chk("bp_valid", 64'(blk_valid), 64'd1);
    chk_blk("bp_snap", snap, exp_q[0]);
    fork
      send_word(32'h6162_6300, 1'b1, 3'd3);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk_blk($sformatf("bp_stable%0d", c), blk_data, snap);
          chk($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
          chk($sformatf("bp_hold_valid%0d", c), 64'(blk_valid), 64'd1);
        end
        chk("bp_no_early_hs", 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #1 blk_ready = 1'b1;
      end
    join
    wait_blocks(3);
    chk("bp_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() >= 3) begin
      chk_blk("bp_blk0", got_q[0].d, exp_q[0]);
      chk("bp_first0", 64'(got_q[0].f), 64'd1);
      chk("bp_last0",  64'(got_q[0].l), 64'd0);
      chk_blk("bp_blk1", got_q[1].d, exp_q[1]);
      chk("bp_last1",  64'(got_q[1].l), 64'd1);
      chk_blk("bp_next_abc", got_q[2].d, abc_blk);
      chk("bp_next_first", 64'(got_q[2].f), 64'd1);
    end

    // Reset after 7 of 16 words
    got_q.delete();
    for (int k = 0; k < 7; k++) send_word(mk_word(64, k), 1'b0, 3'd0);
    @(negedge clk);
    chk("mr_busy_before", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_in_ready",  64'(in_ready),  64'd1);
    chk("mr_blk_valid", 64'(blk_valid), 64'd0);
    chk("mr_blk_first", 64'(blk_first), 64'd0);
    chk("mr_blk_last",  64'(blk_last),  64'd0);
    chk("mr_busy",      64'(busy),      64'd0);
    chk_blk("mr_blk_data", blk_data, '0);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("mr_no_block", 64'(got_q.size()), 64'd0);
    @(posedge clk);
    #1;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_blocks(1);
    chk("mr_abc_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      chk_blk("mr_abc_data", got_q[0].d, abc_blk);
      chk("mr_abc_first", 64'(got_q[0].f), 64'd1);
      chk("mr_abc_last",  64'(got_q[0].l), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
